// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: I/D-cache block refill arbiter owning the pipelined memory read port.
// Define ARB_RR_EN for round-robin arbitration instead of fixed D-cache priority.
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W = 16,
  localparam int WIDX_W = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic [WIDX_W-1:0] fill_word,
  output logic [15:0]       fill_data,
  output logic              fill_done_i,
  output logic              fill_done_d,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_nx;
  logic owner_d;
  logic grant_d;
  logic any_miss;
  logic accept;
  logic [ADDR_W-1:0] base;
  logic [WIDX_W:0] issue_cnt;
  logic [WIDX_W-1:0] recv_cnt;
`ifdef ARB_RR_EN
  logic last_d;
  assign grant_d = dcache_miss & (~icache_miss | ~last_d);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_d <= 1'b0;
    else if (state == IDLE && any_miss) last_d <= grant_d;
`else
  assign grant_d = dcache_miss;
`endif
  always_comb begin
    any_miss = icache_miss | dcache_miss;
    accept = (state == FILL) & mem_data_valid;
    mem_en = (state == FILL) & (issue_cnt < (WIDX_W+1)'(BLOCK_WORDS));
    mem_addr = mem_en ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
    fill_we_i = accept & ~owner_d;
    fill_we_d = accept & owner_d;
    fill_word = recv_cnt;
    fill_data = mem_data;
    fill_done_i = (state == DONE) & ~owner_d;
    fill_done_d = (state == DONE) & owner_d;
    busy = state != IDLE;
    state_nx = state == IDLE ? (any_miss ? FILL : IDLE)
             : state == FILL ? ((accept && recv_cnt == WIDX_W'(BLOCK_WORDS-1)) ? DONE : FILL)
             : IDLE;
  end
  // recv_cnt wraps to zero on the last word, so it is clean for the next block
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner_d <= 1'b0;
      base <= '0;
      issue_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_miss) begin
        owner_d <= grant_d;
        base <= (grant_d ? dcache_addr : icache_addr) & ~ADDR_W'(2*BLOCK_WORDS-1);
      end
      issue_cnt <= (state == FILL) ? issue_cnt + (WIDX_W+1)'(mem_en) : '0;
      if (accept) recv_cnt <= recv_cnt + WIDX_W'(1);
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: randomized scoreboard bench with a latency/gap memory model.
module tb_cache_fill_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic icache_miss = 1'b0, dcache_miss = 1'b0;
  logic [15:0] icache_addr = '0, dcache_addr = '0;
  logic mem_en, mem_data_valid = 1'b0;
  logic [15:0] mem_addr, mem_data = '0, fill_data;
  logic fill_we_i, fill_we_d, fill_done_i, fill_done_d, busy;
  logic [2:0] fill_word;

  cache_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .fill_word(fill_word), .fill_data(fill_data),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  logic [15:0] salt;
  function automatic logic [15:0] memword(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  // memory: fixed latency, words returned in request order, optionally gated
  typedef struct {logic [15:0] a; int due;} mreq_t;
  mreq_t mq[$];
  int lat = 4, vmode = 0;
  bit stray = 0;
  always @(negedge clk) if (mem_en) mq.push_back('{mem_addr, cyc + lat - 1});
  always @(posedge clk) begin
    #1;
    mem_data_valid = 1'b0;
    mem_data = 16'($urandom);
    if (mq.size() > 0 && mq[0].due <= cyc &&
        (vmode == 0 || (vmode == 1 && cyc % 3 == 0) || (vmode == 2 && $urandom_range(0, 1) == 1))) begin
      mem_data_valid = 1'b1;
      mem_data = memword(mq[0].a);
      void'(mq.pop_front());
    end else if (stray) mem_data_valid = 1'b1;
  end

  // reference model: expected responses per granted block
  typedef struct {bit d; int w; logic [15:0] data;} wr_t;
  logic [15:0] exp_req[$];
  wr_t exp_wr[$];
  bit exp_done[$];
  bit m_last_d = 0;

  function automatic void push_block(bit d, logic [15:0] a);
    logic [15:0] b;
    b = a - (a % 16'd16);
    for (int k = 0; k < 8; k++) begin
      exp_req.push_back(16'(b + 2 * k));
      exp_wr.push_back('{d, k, memword(16'(b + 2 * k))});
    end
    exp_done.push_back(d);
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (mem_en) begin
      if (exp_req.size() == 0) check("mem_en_unexpected", mem_en, 0);
      else check("mem_addr", mem_addr, exp_req.pop_front());
    end
    if (fill_we_i || fill_we_d) begin
      wr_t e;
      check("we_exclusive", fill_we_i & fill_we_d, 0);
      if (exp_wr.size() == 0) check("fill_we_unexpected", {fill_we_i, fill_we_d}, 0);
      else begin
        e = exp_wr.pop_front();
        check("fill_cache_d", fill_we_d, e.d);
        check("fill_word", fill_word, e.w);
        check("fill_data", fill_data, e.data);
      end
    end
    if (fill_done_i || fill_done_d) begin
      check("busy_in_done", busy, 1);
      if (exp_done.size() == 0) check("done_unexpected", {fill_done_i, fill_done_d}, 0);
      else check("done_cache_d", fill_done_d, exp_done.pop_front());
    end
  end

  task automatic raise(input bit do_i, input bit do_d, input logic [15:0] ai,
                       input logic [15:0] ad, output int t0, output bit first_d);
    @(posedge clk); #1;
    t0 = cyc;
    if (do_i) begin icache_miss = 1'b1; icache_addr = ai; end
    if (do_d) begin dcache_miss = 1'b1; dcache_addr = ad; end
`ifdef ARB_RR_EN
    first_d = do_d && (!do_i || !m_last_d);
`else
    first_d = do_d;
`endif
    push_block(first_d, first_d ? ad : ai);
    if (do_i && do_d) push_block(!first_d, first_d ? ai : ad);
    m_last_d = (do_i && do_d) ? !first_d : first_d;
  endtask

  task automatic wait_done(input bit d, output int t_req, output int t_we, output int t_done);
    t_req = -1; t_we = -1; t_done = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (mem_en && t_req < 0) t_req = cyc;
      if ((fill_we_i || fill_we_d) && t_we < 0) t_we = cyc;
      if (d ? fill_done_d : fill_done_i) begin t_done = cyc; break; end
    end
    if (t_done < 0) check("done_timeout", d ? fill_done_d : fill_done_i, 1);
    @(posedge clk); #1;
    if (d) dcache_miss = 1'b0; else icache_miss = 1'b0;
  endtask

  task automatic run(input bit do_i, input bit do_d, input logic [15:0] ai, input logic [15:0] ad);
    int t0, tr, tw, td, tr2, tw2, td2;
    bit fd;
    raise(do_i, do_d, ai, ad, t0, fd);
    wait_done(fd, tr, tw, td);
    if (do_i && do_d) begin
      wait_done(!fd, tr2, tw2, td2);
      check("second_grant_cycle", tr2, td + 2);
    end
  endtask

  initial begin
    int t0, tr, tw, td, cnt;
    bit fd;
    salt = 16'($urandom);
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_we_i", fill_we_i, 0);
    check("rst_we_d", fill_we_d, 0);
    check("rst_fill_word", fill_word, 0);
    check("rst_done_i", fill_done_i, 0);
    check("rst_done_d", fill_done_d, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    lat = 4; vmode = 0;
    raise(0, 1, 16'h0, 16'h1236, t0, fd);
    wait_done(1, tr, tw, td);
    check("lat_first_req", tr, t0 + 1);
    check("lat_first_we", tw, t0 + 4);
    check("lat_done", td, t0 + 12);

    lat = 3; vmode = 2;
    run(1, 1, 16'h0040, 16'h0800);
    lat = 5;
    run(1, 0, 16'hFFF2, 16'h0);

    lat = 2; vmode = 1;
    run(0, 1, 16'($urandom), 16'h0);
    @(negedge clk) stray = 1;
    @(negedge clk) begin
      check("stray_valid_seen", mem_data_valid, 1);
      check("stray_no_write", fill_we_i | fill_we_d, 0);
      stray = 0;
    end

    lat = 3; vmode = 0;
    raise(0, 1, 16'h0, 16'h2000, t0, fd);
    repeat (3) @(posedge clk);
    #1 dcache_addr = 16'h3000;
    wait_done(1, tr, tw, td);

    raise(0, 1, 16'h0, 16'h4000, t0, fd);
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 3; n++) begin
      @(negedge clk);
      if (fill_we_d) cnt++;
    end
    check("words_before_reset", cnt, 3);
    #2 rst_n = 1'b0;
    dcache_miss = 1'b0;
    #1;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fill_word", fill_word, 0);
    exp_req.delete(); exp_wr.delete(); exp_done.delete();
    m_last_d = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 50 && mq.size() > 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    run(0, 1, 16'h0, 16'h4000);

    for (int i = 0; i < 12; i++) begin
      int r;
      r = $urandom_range(0, 2);
      lat = $urandom_range(2, 6);
      vmode = $urandom_range(0, 2);
      run(r != 1, r != 0, 16'($urandom), 16'($urandom));
    end

    repeat (10) @(posedge clk);
    check("exp_req_left", exp_req.size(), 0);
    check("exp_wr_left", exp_wr.size(), 0);
    check("exp_done_left", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
